// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M divide unit: func3 encodings, FSM states and default width.
package riscv_m_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step; chained to do several steps per cycle.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0] shifted_s;
    logic [W:0] diff_s;
    logic       ge_s;

    // Shift in the next dividend bit; a set top bit of the old remainder always exceeds the divisor.
    always_comb begin
        shifted_s = {rem_in[W-1:0], quo_in[W-1]};
        diff_s    = shifted_s - {1'b0, divisor};
        ge_s      = rem_in[W] | (shifted_s >= {1'b0, divisor});
        if (ge_s) begin
            rem_out = diff_s;
            quo_out = {quo_in[W-2:0], 1'b1};
        end else begin
            rem_out = shifted_s;
            quo_out = {quo_in[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit using restoring division on magnitudes.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |op_a| < |op_b|.
module div_unit
    import riscv_m_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int STEPS = XLEN / ITER_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(STEPS);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] X_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return ~x + X_ONE;
    endfunction

    div_state_t      state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic [XLEN:0]   rem_r, rem_nxt_s;
    logic [XLEN-1:0] quo_r, quo_nxt_s;
    logic [XLEN-1:0] divisor_r, divisor_nxt_s;
    logic            sel_rem_r, sel_rem_nxt_s;
    logic            q_sign_r, q_sign_nxt_s;
    logic            r_sign_r, r_sign_nxt_s;
    logic [XLEN-1:0] result_r, result_nxt_s;
    logic            done_r;
    logic            busy_r;

    logic            signed_op_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic            div_zero_s;
    logic            overflow_s;
    logic [XLEN-1:0] quo_fix_s;
    logic [XLEN-1:0] rem_fix_s;

    logic [XLEN:0]   rem_c [0:ITER_PER_CYCLE];
    logic [XLEN-1:0] quo_c [0:ITER_PER_CYCLE];

    assign rem_c[0] = rem_r;
    assign quo_c[0] = quo_r;

    for (genvar i = 0; i < ITER_PER_CYCLE; i++) begin : g_step
        div_step #(.W(XLEN)) u_step (
            .rem_in  (rem_c[i]),
            .quo_in  (quo_c[i]),
            .divisor (divisor_r),
            .rem_out (rem_c[i+1]),
            .quo_out (quo_c[i+1])
        );
    end

    assign signed_op_s = ~func3[0];
    assign a_mag_s     = (signed_op_s && op_a[XLEN-1]) ? neg(op_a) : op_a;
    assign b_mag_s     = (signed_op_s && op_b[XLEN-1]) ? neg(op_b) : op_b;
    assign div_zero_s  = (op_b == {XLEN{1'b0}});
    assign overflow_s  = signed_op_s && (op_a == X_MIN) && (op_b == {XLEN{1'b1}});
    assign quo_fix_s   = q_sign_r ? neg(quo_c[ITER_PER_CYCLE]) : quo_c[ITER_PER_CYCLE];
    assign rem_fix_s   = r_sign_r ? neg(rem_c[ITER_PER_CYCLE][XLEN-1:0])
                                  : rem_c[ITER_PER_CYCLE][XLEN-1:0];

    // Next-state and datapath update; the result is formed on entry to DONE so it is stable while done is high.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        rem_nxt_s     = rem_r;
        quo_nxt_s     = quo_r;
        divisor_nxt_s = divisor_r;
        sel_rem_nxt_s = sel_rem_r;
        q_sign_nxt_s  = q_sign_r;
        r_sign_nxt_s  = r_sign_r;
        result_nxt_s  = result_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && func3[2]) begin
                        sel_rem_nxt_s = func3[1];
                        q_sign_nxt_s  = signed_op_s & (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        r_sign_nxt_s  = signed_op_s & op_a[XLEN-1];
                        divisor_nxt_s = b_mag_s;
                        rem_nxt_s     = {(XLEN+1){1'b0}};
                        quo_nxt_s     = a_mag_s;
                        cnt_nxt_s     = CNT_LOAD;
                        if (div_zero_s) begin
                            result_nxt_s = func3[1] ? op_a : {XLEN{1'b1}};
                            state_nxt_s  = DONE;
                        end else if (overflow_s) begin
                            result_nxt_s = func3[1] ? {XLEN{1'b0}} : X_MIN;
                            state_nxt_s  = DONE;
`ifdef DIV_EARLY_OUT_EN
                        end else if (a_mag_s < b_mag_s) begin
                            result_nxt_s = func3[1] ? op_a : {XLEN{1'b0}};
                            state_nxt_s  = DONE;
`endif
                        end else begin
                            state_nxt_s = CALC;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CALC: begin
                    rem_nxt_s = rem_c[ITER_PER_CYCLE];
                    quo_nxt_s = quo_c[ITER_PER_CYCLE];
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        result_nxt_s = sel_rem_r ? rem_fix_s : quo_fix_s;
                        state_nxt_s  = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
                DONE: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            rem_r     <= {(XLEN+1){1'b0}};
            quo_r     <= {XLEN{1'b0}};
            divisor_r <= {XLEN{1'b0}};
            sel_rem_r <= 1'b0;
            q_sign_r  <= 1'b0;
            r_sign_r  <= 1'b0;
            result_r  <= {XLEN{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            rem_r     <= rem_nxt_s;
            quo_r     <= quo_nxt_s;
            divisor_r <= divisor_nxt_s;
            sel_rem_r <= sel_rem_nxt_s;
            q_sign_r  <= q_sign_nxt_s;
            r_sign_r  <= r_sign_nxt_s;
            result_r  <= result_nxt_s;
            done_r    <= (state_nxt_s == DONE);
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operations against an arithmetic model.
module tb_div_unit;
    import riscv_m_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] op_a  = 32'd0;
    logic [31:0] op_b  = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          nvec = 0;
    int          nmis = 0;
    logic [31:0] last_exp = 32'd0;

    div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
        if (!f3[0]) begin
            sa = a;
            sb = b;
            return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f3[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (!f3[0] && a[31]) ? -a : a;
        mb = (!f3[0] && b[31]) ? -b : b;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op in the current cycle, hold start (with changing operands) until done, then check.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic        got;
        logic [31:0] exp_r;
        exp_r = ref_div(f3, a, b);
        start = 1'b1;
        func3 = f3;
        op_a  = a;
        op_b  = b;
        lat   = 0;
        got   = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk($sformatf("%s_busy", tag), 32'(busy), 32'd1);
            op_a = $urandom;
            op_b = $urandom;
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        chk($sformatf("%s_lat", tag), 32'(lat), 32'(ref_lat(f3, a, b)));
        chk($sformatf("%s_res", tag), result, exp_r);
        last_exp = exp_r;
        @(negedge clk);
        chk($sformatf("%s_pulse", tag), {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", {30'd0, busy, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op("div100_7",  F3_DIV,  32'd100,        32'd7);
        do_op("rem100_7",  F3_REM,  32'd100,        32'd7);
        do_op("div_m7_2",  F3_DIV,  32'hFFFF_FFF9,  32'd2);
        do_op("rem_m7_2",  F3_REM,  32'hFFFF_FFF9,  32'd2);
        do_op("divu_m7_2", F3_DIVU, 32'hFFFF_FFF9,  32'd2);
        do_op("divu_5_0",  F3_DIVU, 32'd5,          32'd0);
        do_op("rem_5_0",   F3_REM,  32'd5,          32'd0);
        do_op("div_ovf",   F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF);
        do_op("rem_ovf",   F3_REM,  32'h8000_0000,  32'hFFFF_FFFF);
        do_op("divu_3_10", F3_DIVU, 32'd3,          32'd10);
        do_op("remu_3_10", F3_REMU, 32'd3,          32'd10);
        do_op("rem_m3_10", F3_REM,  32'hFFFF_FFFD,  32'd10);

        // Non-divide func3 must be ignored.
        start = 1'b1;
        func3 = 3'b001;
        repeat (3) begin
            @(negedge clk);
            chk("nondiv_busy", 32'(busy), 32'd0);
        end
        // flush together with start in IDLE: flush wins.
        func3 = F3_DIV;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_start", 32'(busy), 32'd0);
        flush = 1'b0;
        start = 1'b0;

        // Flush at T+10 of a DIV.
        start = 1'b1;
        func3 = F3_DIV;
        op_a  = 32'h1234_5678;
        op_b  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            chk("flush_nodone", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("flush_nodone", 32'(done), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {30'd0, busy, done}, 32'd0);
        chk("flush_result", result, last_exp);
        do_op("after_flush", F3_DIVU, 32'hDEAD_BEEF, 32'd17);

        // Reset at T+5 mid-CALC.
        start = 1'b1;
        func3 = F3_REMU;
        op_a  = 32'hCAFE_F00D;
        op_b  = 32'd9;
        repeat (5) @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_state", {30'd0, busy, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_nodone", 32'(done), 32'd0);
        end
        do_op("after_rst", F3_DIV, 32'hFFFF_F000, 32'd12);

        for (int n = 0; n < 30; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = {1'b1, 2'($urandom)};
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(51, 1000)); end
                3: ;
                4: begin a = 32'($urandom_range(0, 500)); b = 32'($urandom_range(1, 20)); end
                default: b = 32'($urandom_range(1, 255)) | (b & 32'h8000_0000);
            endcase
            do_op($sformatf("rnd%0d", n), f3, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
